rom_burst_reader: RTL and testbench

- Parametrised, pipelined successor to the single-word ROM reader used by the RC4 key/data path.
- On a start handshake, bursts `length` consecutive words out of a synchronous ROM, beginning at a programmable base address. Each word is captured into an output register array.
- Issues one address per clock and tolerates a configurable ROM read latency, so a 32-word load costs ~34 cycles instead of ~96.
- Supports abort and repeated restarts without reset; feeds the key-schedule and decrypt FSMs.

---
 rtl/rom_burst_reader.sv | 139 +++++++++++++
 tb/tb_rom_burst_reader.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/rom_burst_reader.sv
// rom_burst_reader
//   Reads `length` consecutive words from a synchronous ROM, one address per
//   clock, starting at `base_addr`, and captures word i into rom_data[i].
//   A ROM_LATENCY-deep tag pipeline follows each issued address so the
//   returning data lands in the right entry whatever the ROM latency is.
//
// Ports
//   clk           in   system clock, rising edge
//   reset         in   asynchronous active-low reset
//   start         in   begin a burst (accepted in IDLE or DONE)
//   abort         in   cancel the active burst (RUN or DRAIN)
//   base_addr     in   first ROM address, latched at start
//   length        in   words to read, latched at start, clamped to DEPTH
//   rom_q_data_in in   ROM read data
//   rom_address   out  registered ROM address
//   rom_data      out  capture array, entry i = ROM[base+i]
//   busy          out  high in RUN and DRAIN
//   done          out  high in DONE until the next accepted start
//   words_read    out  words captured in the current burst
module rom_burst_reader #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 5,
    parameter int DEPTH       = 32,
    parameter int ROM_LATENCY = 1,
    parameter int LEN_W       = $clog2(DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         abort,
    input  logic [ADDR_W-1:0]            base_addr,
    input  logic [LEN_W-1:0]             length,
    input  logic [DATA_W-1:0]            rom_q_data_in,
    output logic [ADDR_W-1:0]            rom_address,
    output logic [DEPTH-1:0][DATA_W-1:0] rom_data,
    output logic                         busy,
    output logic                         done,
    output logic [LEN_W-1:0]             words_read
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [LEN_W-1:0]       len_clamped;
    logic [LEN_W-1:0]       len_q;
    logic [LEN_W-1:0]       last_idx;
    logic [LEN_W-1:0]       issue_cnt;
    logic [ROM_LATENCY-1:0] tag_v;
    logic [LEN_W-1:0]       tag_idx [ROM_LATENCY];

    logic start_acc;
    logic issue;
    logic last_issue;
    logic capture;
    logic last_capture;

    assign len_clamped = (length > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : length;
    assign last_idx    = len_q - LEN_W'(1);

    always_comb begin
        busy         = (state == S_RUN) || (state == S_DRAIN);
        done         = (state == S_DONE);
        start_acc    = start && ((state == S_IDLE) || (state == S_DONE));
        issue        = (state == S_RUN) && !abort;
        last_issue   = issue && (issue_cnt == last_idx);
        // The oldest tag leaves the pipeline exactly when its data is valid.
        capture      = tag_v[ROM_LATENCY-1] && busy && !abort;
        last_capture = capture && (tag_idx[ROM_LATENCY-1] == last_idx);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) state_nxt = (len_clamped == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                if (abort)           state_nxt = S_IDLE;
                else if (last_issue) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (abort)             state_nxt = S_IDLE;
                else if (last_capture) state_nxt = S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rom_address <= '0;
            rom_data    <= '0;
            words_read  <= '0;
            len_q       <= '0;
            issue_cnt   <= '0;
            tag_v       <= '0;
            for (int unsigned k = 0; k < ROM_LATENCY; k++) tag_idx[k] <= '0;
        end else begin
            if (start_acc) begin
                len_q       <= len_clamped;
                issue_cnt   <= '0;
                words_read  <= '0;
                rom_address <= base_addr;
            end else if (issue && !last_issue) begin
                issue_cnt   <= issue_cnt + LEN_W'(1);
                rom_address <= rom_address + ADDR_W'(1);
            end

            tag_v[0]   <= issue;
            tag_idx[0] <= issue_cnt;
            for (int unsigned k = 1; k < ROM_LATENCY; k++) begin
                tag_v[k]   <= tag_v[k-1];
                tag_idx[k] <= tag_idx[k-1];
            end
            // Abort kills every in-flight read; the later assignment wins
            // over the shift above.
            if (abort && busy) tag_v <= '0;

            if (capture) begin
                words_read <= words_read + LEN_W'(1);
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (tag_idx[ROM_LATENCY-1] == LEN_W'(i)) rom_data[i] <= rom_q_data_in;
                end
            end
        end
    end

endmodule

// File: tb/tb_rom_burst_reader.sv
module tb_rom_burst_reader;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             start3;
    logic             abort;
    logic [4:0]       base_addr;
    logic [5:0]       length;
    logic [7:0]       rom_q;
    logic [7:0]       rom_q3;
    logic [4:0]       rom_address;
    logic [4:0]       rom_address3;
    logic [31:0][7:0] rom_data;
    logic [31:0][7:0] rom_data3;
    logic             busy, busy3;
    logic             done, done3;
    logic [5:0]       words_read, words_read3;

    logic [31:0][7:0] exp_vec;
    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rom_burst_reader dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .base_addr(base_addr), .length(length), .rom_q_data_in(rom_q),
        .rom_address(rom_address), .rom_data(rom_data), .busy(busy),
        .done(done), .words_read(words_read)
    );

    rom_burst_reader #(.ROM_LATENCY(3)) dut3 (
        .clk(clk), .reset(reset), .start(start3), .abort(abort),
        .base_addr(base_addr), .length(length), .rom_q_data_in(rom_q3),
        .rom_address(rom_address3), .rom_data(rom_data3), .busy(busy3),
        .done(done3), .words_read(words_read3)
    );

    function automatic logic [7:0] romf(input logic [4:0] a);
        return {3'b000, a} ^ 8'hA5;
    endfunction

    // ROM models: 1-cycle and 3-cycle read pipelines
    logic [7:0] p0, p1;
    always @(posedge clk) begin
        rom_q  <= romf(rom_address);
        p0     <= romf(rom_address3);
        p1     <= p0;
        rom_q3 <= p1;
    end

    // Runs one burst on dut and measures it; comparisons are made by callers.
    task automatic burst(input logic [4:0] b, input logic [5:0] l,
                         output int done_at, output int busy_cnt, output int addr_err);
        int lc;
        logic [4:0] ea;
        lc = (l > 6'd32) ? 32 : int'(l);
        done_at = 0; busy_cnt = 0; addr_err = 0;
        @(negedge clk);
        base_addr = b; length = l; start = 1'b1;
        for (int n = 1; n <= 80 && done_at == 0; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy === 1'b1) busy_cnt++;
            if (n <= lc) begin
                ea = b + 5'(n - 1);
                if (rom_address !== ea) addr_err++;
            end
            if (done === 1'b1) done_at = n;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp++; if (rom_address !== 5'd0) begin n_fail++; $display("FAIL reset_addr: got %0d expected 0", rom_address); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_cmp++; if (words_read !== 6'd0) begin n_fail++; $display("FAIL reset_words: got %0d expected 0", words_read); end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++; if (rom_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", rom_data); end
        n_cmp++; if (rom_data3 !== '0 || busy3 !== 1'b0 || done3 !== 1'b0) begin
            n_fail++; $display("FAIL reset_dut3: got busy=%b done=%b expected 0 0", busy3, done3); end
    endtask

    task automatic test_full();
        int d, bc, ae;
        burst(5'd0, 6'd32, d, bc, ae);
        for (int i = 0; i < 32; i++) exp_vec[i] = romf(5'(i));
        n_cmp++; if (d != 34) begin n_fail++; $display("FAIL full_done_at: got %0d expected 34", d); end
        n_cmp++; if (bc != 33) begin n_fail++; $display("FAIL full_busy: got %0d expected 33", bc); end
        n_cmp++; if (ae != 0) begin n_fail++; $display("FAIL full_addr: got %0d bad expected 0", ae); end
        n_cmp++; if (rom_data !== exp_vec) begin n_fail++; $display("FAIL full_data: got %h expected %h", rom_data, exp_vec); end
        n_cmp++; if (words_read !== 6'd32) begin n_fail++; $display("FAIL full_words: got %0d expected 32", words_read); end
    endtask

    task automatic test_wrap();
        int d, bc, ae;
        burst(5'd30, 6'd4, d, bc, ae);
        exp_vec[0] = romf(5'd30); exp_vec[1] = romf(5'd31);
        exp_vec[2] = romf(5'd0);  exp_vec[3] = romf(5'd1);
        n_cmp++; if (d != 6) begin n_fail++; $display("FAIL wrap_done_at: got %0d expected 6", d); end
        n_cmp++; if (ae != 0) begin n_fail++; $display("FAIL wrap_addr: got %0d bad expected 0", ae); end
        n_cmp++; if (rom_data !== exp_vec) begin n_fail++; $display("FAIL wrap_data: got %h expected %h", rom_data, exp_vec); end
        n_cmp++; if (words_read !== 6'd4) begin n_fail++; $display("FAIL wrap_words: got %0d expected 4", words_read); end
    endtask

    task automatic test_zero_len();
        int d, bc, ae;
        burst(5'd5, 6'd0, d, bc, ae);
        repeat (3) @(negedge clk);
        n_cmp++; if (d != 1) begin n_fail++; $display("FAIL zero_done_at: got %0d expected 1", d); end
        n_cmp++; if (bc != 0) begin n_fail++; $display("FAIL zero_busy: got %0d expected 0", bc); end
        n_cmp++; if (rom_data !== exp_vec) begin n_fail++; $display("FAIL zero_data: got %h expected %h", rom_data, exp_vec); end
        n_cmp++; if (words_read !== 6'd0) begin n_fail++; $display("FAIL zero_words: got %0d expected 0", words_read); end
    endtask

    task automatic test_clamp();
        int d, bc, ae;
        burst(5'd0, 6'd40, d, bc, ae);
        for (int i = 0; i < 32; i++) exp_vec[i] = romf(5'(i));
        n_cmp++; if (d != 34) begin n_fail++; $display("FAIL clamp_done_at: got %0d expected 34", d); end
        n_cmp++; if (words_read !== 6'd32) begin n_fail++; $display("FAIL clamp_words: got %0d expected 32", words_read); end
        n_cmp++; if (rom_data !== exp_vec) begin n_fail++; $display("FAIL clamp_data: got %h expected %h", rom_data, exp_vec); end
    endtask

    task automatic test_latency3();
        int d;
        logic [31:0][7:0] exp3;
        exp3 = '0;
        for (int i = 0; i < 8; i++) exp3[i] = romf(5'(i));
        d = 0;
        @(negedge clk);
        base_addr = 5'd0; length = 6'd8; start3 = 1'b1;
        for (int n = 1; n <= 80 && d == 0; n++) begin
            @(negedge clk);
            start3 = 1'b0;
            if (done3 === 1'b1) d = n;
        end
        n_cmp++; if (d != 12) begin n_fail++; $display("FAIL lat3_done_at: got %0d expected 12", d); end
        n_cmp++; if (rom_data3 !== exp3) begin n_fail++; $display("FAIL lat3_data: got %h expected %h", rom_data3, exp3); end
        n_cmp++; if (words_read3 !== 6'd8) begin n_fail++; $display("FAIL lat3_words: got %0d expected 8", words_read3); end
    endtask

    task automatic test_start_ignored();
        int d, ae;
        logic [4:0] ea;
        d = 0; ae = 0;
        @(negedge clk);
        base_addr = 5'd3; length = 6'd16; start = 1'b1;
        for (int n = 1; n <= 80 && d == 0; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (n <= 16) begin
                ea = 5'd3 + 5'(n - 1);
                if (rom_address !== ea) ae++;
            end
            if (n == 5) begin start = 1'b1; base_addr = 5'd20; length = 6'd2; end
            if (done === 1'b1) d = n;
        end
        for (int i = 0; i < 16; i++) exp_vec[i] = romf(5'(3 + i));
        n_cmp++; if (d != 18) begin n_fail++; $display("FAIL ign_done_at: got %0d expected 18", d); end
        n_cmp++; if (ae != 0) begin n_fail++; $display("FAIL ign_addr: got %0d bad expected 0", ae); end
        n_cmp++; if (rom_data !== exp_vec) begin n_fail++; $display("FAIL ign_data: got %h expected %h", rom_data, exp_vec); end
        n_cmp++; if (words_read !== 6'd16) begin n_fail++; $display("FAIL ign_words: got %0d expected 16", words_read); end
    endtask

    task automatic test_abort();
        int wr, d, bc, ae;
        @(negedge clk);
        base_addr = 5'd0; length = 6'd20; start = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            start = 1'b0;
        end
        // abort together with start: abort must win
        abort = 1'b1; start = 1'b1; base_addr = 5'd25;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %b expected 0", done); end
        wr = int'(words_read);
        n_cmp++; if (wr < 1 || wr > 10) begin n_fail++; $display("FAIL abort_words: got %0d expected 1..10", wr); end
        repeat (5) @(negedge clk);
        n_cmp++; if (int'(words_read) != wr || busy !== 1'b0) begin
            n_fail++; $display("FAIL abort_quiet: got words=%0d busy=%b expected words=%0d busy=0", words_read, busy, wr); end
        for (int i = 0; i < 32; i++) if (i < wr) exp_vec[i] = romf(5'(i));
        n_cmp++; if (rom_data !== exp_vec) begin n_fail++; $display("FAIL abort_data: got %h expected %h", rom_data, exp_vec); end
        burst(5'd10, 6'd5, d, bc, ae);
        for (int i = 0; i < 5; i++) exp_vec[i] = romf(5'(10 + i));
        n_cmp++; if (d != 7) begin n_fail++; $display("FAIL restart_done_at: got %0d expected 7", d); end
        n_cmp++; if (rom_data !== exp_vec) begin n_fail++; $display("FAIL restart_data: got %h expected %h", rom_data, exp_vec); end
    endtask

    task automatic test_async_reset();
        int d, bc, ae;
        @(negedge clk);
        base_addr = 5'd0; length = 6'd32; start = 1'b1;
        repeat (5) begin
            @(negedge clk);
            start = 1'b0;
        end
        #2 reset = 1'b0;
        #1;
        n_cmp++; if (rom_address !== 5'd0 || busy !== 1'b0 || done !== 1'b0 || words_read !== 6'd0) begin
            n_fail++; $display("FAIL async_outputs: got addr=%0d busy=%b done=%b words=%0d expected all 0",
                               rom_address, busy, done, words_read); end
        n_cmp++; if (rom_data !== '0) begin n_fail++; $display("FAIL async_data: got %h expected 0", rom_data); end
        @(posedge clk); #1;
        n_cmp++; if (words_read !== 6'd0 || rom_data !== '0) begin
            n_fail++; $display("FAIL async_hold: got words=%0d expected 0", words_read); end
        @(negedge clk);
        reset = 1'b1;
        exp_vec = '0;
        burst(5'd7, 6'd3, d, bc, ae);
        for (int i = 0; i < 3; i++) exp_vec[i] = romf(5'(7 + i));
        n_cmp++; if (d != 5) begin n_fail++; $display("FAIL post_reset_done_at: got %0d expected 5", d); end
        n_cmp++; if (rom_data !== exp_vec) begin n_fail++; $display("FAIL post_reset_data: got %h expected %h", rom_data, exp_vec); end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; start3 = 1'b0; abort = 1'b0;
        base_addr = '0; length = '0;
        exp_vec = '0;
        test_reset();
        test_full();
        test_wrap();
        test_zero_len();
        test_clamp();
        test_latency3();
        test_start_ignored();
        test_abort();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
